stopwatch_ctrl: RTL and testbench

//  Control FSM that sequences the 4-digit stopwatch counter (min:sec.tenths).

---
 rtl/stopwatch_ctrl.sv | 132 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronizes and debounces the board buttons/switch and sequences
// the min:sec.tenths counter (clear, enable per tenths tick, direction) without ever wrapping it.
module stopwatch_ctrl #(
    parameter int DB_CNT   = 1_000_000,
    parameter int TICK_DIV = 10_000_000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       btn_start,
    input  logic       btn_reset,
    input  logic       sw_up,
    input  logic [3:0] min,
    input  logic [3:0] secmsd,
    input  logic [3:0] seclsd,
    input  logic [3:0] ten,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       running,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CW = $clog2(DB_CNT + 1);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CNT - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t        st, st_next;
    logic [2:0]    sync1, sync2, lvl;
    logic [1:0]    lvl_d, press;
    logic [CW-1:0] dbc [3];
    logic [PW-1:0] presc;
    logic          at_limit, tick, start_p, reset_p;
    logic          clr_next, en_next, up_next;

    // Bit 0 = start, bit 1 = reset, bit 2 = direction switch
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= 3'b100;
            lvl_d <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) dbc[i] <= '0;
        end else begin
            sync1 <= {sw_up, btn_reset, btn_start};
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (dbc[i] == DB_LAST) begin
                        lvl[i] <= sync2[i];
                        dbc[i] <= '0;
                    end else begin
                        dbc[i] <= dbc[i] + 1'b1;
                    end
                end else begin
                    dbc[i] <= '0;
                end
            end
            lvl_d <= lvl[1:0];
            press <= lvl[1:0] & ~lvl_d;
        end
    end

    assign start_p  = press[0];
    assign reset_p  = press[1];
    assign at_limit = cnt_up ? ({min, secmsd, seclsd, ten} == 16'h9599)
                             : ({min, secmsd, seclsd, ten} == 16'h0000);
    assign tick     = (st == RUN) && (presc == TICK_LAST);

    // Prescaler idles at zero outside RUN, so every entry to RUN starts a full tick period
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            presc <= '0;
        end else if (st != RUN || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        st_next  = st;
        clr_next = 1'b0;
        en_next  = 1'b0;
        up_next  = (st != RUN) ? lvl[2] : cnt_up;
        if (reset_p) begin
            st_next  = IDLE;
            clr_next = 1'b1;
        end else begin
            case (st)
                IDLE:    if (start_p && !at_limit) st_next = RUN;
                RUN: begin
                    if (start_p) begin
                        st_next = PAUSE;
                    end else if (tick) begin
                        if (at_limit) st_next = DONE;
                        else          en_next = 1'b1;
                    end
                end
                PAUSE:   if (start_p && !at_limit) st_next = RUN;
                default: st_next = st;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st      <= IDLE;
            cnt_clr <= 1'b1;
            cnt_en  <= 1'b0;
            cnt_up  <= 1'b1;
            running <= 1'b0;
        end else begin
            st      <= st_next;
            cnt_clr <= clr_next;
            cnt_en  <= en_next;
            cnt_up  <= up_next;
            running <= (st_next == RUN);
        end
    end

    assign state = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a BCD counter model closing the digit feedback loop.
module tb_stopwatch_ctrl;

    localparam int DB = 4;
    localparam int TD = 5;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_reset = 1'b0;
    logic        sw_up = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic        load_req = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        cnt_clr, cnt_en, cnt_up, running;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;
    int en_cnt = 0, clr_cnt = 0, clr_hi = 0, pause_cyc = 0;
    bit clr_prev = 1'b0;
    int e0, c0, h0, p0;

    stopwatch_ctrl #(.DB_CNT(DB), .TICK_DIV(TD)) dut (
        .clk(clk), .clr_n(clr_n), .btn_start(btn_start), .btn_reset(btn_reset),
        .sw_up(sw_up), .min(digits[15:12]), .secmsd(digits[11:8]),
        .seclsd(digits[7:4]), .ten(digits[3:0]),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_up(cnt_up),
        .running(running), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_step(input logic [15:0] d, input logic up);
        logic [3:0] m, a, b, t;
        {m, a, b, t} = d;
        if (up) begin
            if (t == 4'd9) begin
                t = 4'd0;
                if (b == 4'd9) begin
                    b = 4'd0;
                    if (a == 4'd5) begin a = 4'd0; m = (m == 4'd9) ? 4'd0 : m + 4'd1; end
                    else a = a + 4'd1;
                end else b = b + 4'd1;
            end else t = t + 4'd1;
        end else begin
            if (t == 4'd0) begin
                t = 4'd9;
                if (b == 4'd0) begin
                    b = 4'd9;
                    if (a == 4'd0) begin a = 4'd5; m = (m == 4'd0) ? 4'd9 : m - 4'd1; end
                    else a = a - 4'd1;
                end else b = b - 4'd1;
            end else t = t - 4'd1;
        end
        return {m, a, b, t};
    endfunction

    // External counter model: the digits the DUT watches for its limit
    always @(posedge clk) begin
        if (load_req)     digits <= load_val;
        else if (cnt_clr) digits <= 16'h0000;
        else if (cnt_en)  digits <= bcd_step(digits, cnt_up);
    end

    always @(negedge clk) begin
        if (cnt_en) en_cnt <= en_cnt + 1;
        if (cnt_clr) clr_hi <= clr_hi + 1;
        if (cnt_clr && !clr_prev) clr_cnt <= clr_cnt + 1;
        clr_prev <= cnt_clr;
        if (state == 2'd2) pause_cyc <= pause_cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input bit s, input bit r);
        btn_start = s;
        btn_reset = r;
        step(DB + 6);
        btn_start = 1'b0;
        btn_reset = 1'b0;
        step(DB + 6);
    endtask

    task automatic load(input logic [15:0] v);
        load_val = v;
        load_req = 1'b1;
        step(1);
        load_req = 1'b0;
    endtask

    initial begin
        // 1: reset values, release
        step(3);
        check("rst_clr", cnt_clr, 1);
        check("rst_en", cnt_en, 0);
        check("rst_up", cnt_up, 1);
        check("rst_state", state, 0);
        check("rst_running", running, 0);
        clr_n = 1'b1;
        step(1);
        check("rel_clr", cnt_clr, 0);
        step(10);
        check("rel_state", state, 0);
        check("rel_up", cnt_up, 1);

        // 2: start press latency and tick cadence
        btn_start = 1'b1;
        step(DB + 3);
        check("t2_pre_run", state, 0);
        step(1);
        check("t2_run", state, 1);
        check("t2_running", running, 1);
        step(TD - 1);
        check("t2_en_early", cnt_en, 0);
        step(1);
        check("t2_en_first", cnt_en, 1);
        step(1);
        check("t2_en_width", cnt_en, 0);
        step(TD - 1);
        check("t2_en_second", cnt_en, 1);
        btn_start = 1'b0;
        step(12);
        btn_start = 1'b1;
        step(DB + 4);
        check("t2_pause", state, 2);
        btn_start = 1'b0;
        step(12);
        e0 = en_cnt;
        step(20);
        check("t2_pause_no_en", en_cnt - e0, 0);
        check("t2_pause_hold", state, 2);

        // 3: count down, limit at zero
        c0 = clr_cnt;
        push(1'b0, 1'b1);
        check("t3_reset_state", state, 0);
        check("t3_reset_clr", clr_cnt - c0, 1);
        check("t3_digits_clr", digits, 16'h0000);
        sw_up = 1'b0;
        step(DB + 6);
        check("t3_up_idle", cnt_up, 0);
        push(1'b1, 1'b0);
        check("t3_start_ignored", state, 0);
        load(16'h0009);
        push(1'b1, 1'b0);
        check("t3_run", state, 1);
        push(1'b1, 1'b0);
        check("t3_pause", state, 2);
        load(16'h0003);
        e0 = en_cnt;
        push(1'b1, 1'b0);
        step(20);
        check("t3_pulses", en_cnt - e0, 3);
        check("t3_done", state, 3);
        check("t3_digits", digits, 16'h0000);
        step(20);
        check("t3_no_4th", en_cnt - e0, 3);

        // 4: count up to 9:59.9
        push(1'b0, 1'b1);
        sw_up = 1'b1;
        step(DB + 6);
        check("t4_up", cnt_up, 1);
        load(16'h9598);
        e0 = en_cnt;
        push(1'b1, 1'b0);
        check("t4_pulses", en_cnt - e0, 1);
        check("t4_done", state, 3);
        check("t4_digits", digits, 16'h9599);
        push(1'b1, 1'b0);
        check("t4_done_hold", state, 3);
        check("t4_no_more_en", en_cnt - e0, 1);

        // 5: simultaneous start and reset in RUN
        push(1'b0, 1'b1);
        push(1'b1, 1'b0);
        check("t5_run", state, 1);
        c0 = clr_cnt;
        h0 = clr_hi;
        p0 = pause_cyc;
        push(1'b1, 1'b1);
        check("t5_idle", state, 0);
        check("t5_clr_pulses", clr_cnt - c0, 1);
        check("t5_clr_width", clr_hi - h0, 1);
        check("t5_never_pause", pause_cyc - p0, 0);
        check("t5_running", running, 0);

        // 6: bouncing button, direction change deferred during RUN
        for (int i = 0; i < 20; i++) begin
            btn_start = ~btn_start;
            step(2);
        end
        btn_start = 1'b0;
        step(10);
        check("t6_bounce_state", state, 0);
        check("t6_bounce_running", running, 0);
        push(1'b1, 1'b0);
        check("t6_run", state, 1);
        sw_up = 1'b0;
        step(DB + 6);
        check("t6_up_held", cnt_up, 1);
        check("t6_still_run", state, 1);
        push(1'b1, 1'b0);
        check("t6_pause", state, 2);
        check("t6_up_loaded", cnt_up, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
